lif_hebbian_nin: RTL and testbench
==================================

# lif_hebbian_nin

Parametrised successor of the 3-input online-Hebbian LIF neuron: N_IN binary spike inputs, per-synapse learned weights, a saturating membrane integrator with leak, an absolute refractory period, and trace-based LTP/LTD applied on each output spike. It is the single-neuron building block for the SNN layer. Learning and time-stepping are gated by enables so a layer controller can freeze weights or stall the neuron.

## Interface
- N_IN, 8: number of synaptic inputs (≥1)
- W_W, 8: weight width, unsigned
- V_W, 12: membrane potential width, unsigned
- V_THRESH, 512: fire when potential ≥ V_THRESH (< 2^V_W)
- V_RESET, 0: potential after a spike and during refractory
- LEAK, 2: subtracted every integrating tick
- ETA, 4: LTP increment
- DECAY_SHIFT, 4: LTD amount is w >> DECAY_SHIFT
- W_MAX, 255: weight ceiling (≤ 2^W_W−1)
- W_INIT, 32: weight value after reset
- T_REFRAC, 4: refractory length in enabled ticks (0 = none)
- TRACE_MAX, 15: presynaptic trace load value; trace width = clog2(TRACE_MAX+1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  tick enable; 0 holds all state
- learn_en  in  1  weight update enable
- x  in  N_IN  input spikes, bit i = synapse i
- spike_out  out  1  one-tick output spike pulse (registered)
- v_out  out  V_W  current membrane potential
- w_flat  out  N_IN*W_W  weights, w[i] at bits [i*W_W +: W_W]
- refrac_active  out  1  high while in REFRACTORY

## Operation
- Reset (async, reset_n=0): V=0, all w=W_INIT, all traces=0, state=INTEGRATE, refractory count=0, spike_out=0, refrac_active=0.
- en=0: V, w, traces, state, counter held; spike_out forced 0 next edge.
- Traces (every en tick, both states): tr[i] <= x[i] ? TRACE_MAX : (tr[i]==0 ? 0 : tr[i]−1).
- INTEGRATE: sum = Σ x[i]·w[i] (width W_W+clog2(N_IN)); Vn = V + sum − LEAK computed signed with two guard bits; clamp to [0, 2^V_W−1].
  - Vn < V_THRESH: V <= Vn, spike_out <= 0.
  - Vn ≥ V_THRESH: spike_out <= 1, V <= V_RESET; if T_REFRAC>0 go REFRACTORY with count=T_REFRAC, else stay INTEGRATE.
- REFRACTORY: inputs not integrated, V held at V_RESET, spike_out 0, count decrements each en tick; on the tick count goes 1→0, return to INTEGRATE. Exactly T_REFRAC enabled ticks are spent refractory.
- Learning, only on a spiking tick with learn_en=1: eligible[i] = x[i] | (tr[i]≠0), using pre-update trace.
  - eligible: w[i] <= min(w[i]+ETA, W_MAX).
  - not eligible: w[i] <= w[i] − (w[i]>>DECAY_SHIFT) (never underflows; small weights may stick).
- No weight change on non-spiking ticks or when learn_en=0.

## Timing
- Single-cycle: x sampled at edge k determines V, spike_out, w, tr visible after edge k.
- The new weights from a spike take effect for integration from edge k+1 onward.
- spike_out is high for exactly one cycle per spike; refrac_active rises the same edge spike_out rises.
- Reset mid-refractory or mid-integration: immediate return to reset values; no pending spike survives.
- learn_en/en changes take effect at the next edge, no pipeline.

## Structure
- Package lif_pkg: state enum {INTEGRATE, REFRACTORY}, saturating add/sub functions, trace-width localparam helper.
- Sub-module lif_syn_cell (one per synapse, via generate): holds w[i] and tr[i], takes x[i], spike, learn_en, en; outputs w[i] and weighted contribution. Top holds adder tree, membrane, FSM.

## Test plan
- Reset: hold reset_n=0 → v_out=0, spike_out=0, refrac_active=0, w_flat = eight copies of 32.
- x=8'h01, learn_en=1: V = 30, 60, … spike on 18th tick (540≥512); w0→36, w1..w7→30; refrac_active 4 ticks with v_out=0; next spike after 16 integrating ticks (16·34=544).
- x=8'hFF: V=254, 508, spike on 3rd tick; all weights 32→36.
- Repeat x=8'h01 with learn_en=0 → identical spike timing every period (18 ticks + 4 refractory), weights stay 32.
- x=0 for 100 ticks from V=0 → v_out stays 0 (no underflow wrap); en=0 for 10 ticks mid-integration → v_out, w_flat frozen, spike_out=0.
- x=8'hFF with learn_en=1 for many spikes → all weights clamp at 255 and stay; assert reset_n=0 during refractory → refrac_active drops immediately, weights return to 32.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the Hebbian LIF neuron: FSM state encoding,
// saturating arithmetic and trace-width sizing.
package lif_pkg;

  typedef enum logic [0:0] {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

  function automatic int trace_width(input int trace_max);
    return (trace_max < 1) ? 1 : $clog2(trace_max + 1);
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned lim);
    return ((a + b) > lim) ? lim : (a + b);
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/lif_syn_cell.sv
// One synapse: learned weight plus presynaptic eligibility trace, with
// trace-gated LTP / proportional LTD applied when the neuron fires.
module lif_syn_cell
  import lif_pkg::*;
#(
  parameter int W_W         = 8,
  parameter int ETA         = 4,
  parameter int DECAY_SHIFT = 4,
  parameter int W_MAX       = 255,
  parameter int W_INIT      = 32,
  parameter int TRACE_MAX   = 15,
  parameter int TR_W        = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en_i,
  input  logic           learn_en_i,
  input  logic           x_i,
  input  logic           spike_i,
  output logic [W_W-1:0] w_o,
  output logic [W_W-1:0] contrib_o
);

  logic [W_W-1:0]  w_q, w_d;
  logic [TR_W-1:0] tr_q, tr_d;
  logic            elig_s;

  // Weight and trace registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q  <= W_W'(W_INIT);
      tr_q <= '0;
    end else begin
      w_q  <= w_d;
      tr_q <= tr_d;
    end
  end

  // Eligibility uses the trace value from before this tick's reload/decay
  always_comb begin
    elig_s = x_i | (tr_q != '0);
    w_d    = w_q;
    tr_d   = tr_q;
    if (en_i) begin
      if (x_i) begin
        tr_d = TR_W'(TRACE_MAX);
      end else if (tr_q != '0) begin
        tr_d = tr_q - TR_W'(1);
      end else begin
        tr_d = '0;
      end
      if (spike_i && learn_en_i) begin
        if (elig_s) begin
          w_d = W_W'(sat_add(32'(w_q), 32'(ETA), 32'(W_MAX)));
        end else begin
          w_d = W_W'(sat_sub(32'(w_q), 32'(w_q >> DECAY_SHIFT)));
        end
      end else begin
        w_d = w_q;
      end
    end else begin
      w_d  = w_q;
      tr_d = tr_q;
    end
  end

  assign w_o       = w_q;
  assign contrib_o = x_i ? w_q : '0;

endmodule

// File: rtl/lif_hebbian_nin.sv
// N_IN-input leaky integrate-and-fire neuron with absolute refractory period
// and online trace-based Hebbian weight learning on each output spike.
module lif_hebbian_nin
  import lif_pkg::*;
#(
  parameter int N_IN        = 8,
  parameter int W_W         = 8,
  parameter int V_W         = 12,
  parameter int V_THRESH    = 512,
  parameter int V_RESET     = 0,
  parameter int LEAK        = 2,
  parameter int ETA         = 4,
  parameter int DECAY_SHIFT = 4,
  parameter int W_MAX       = 255,
  parameter int W_INIT      = 32,
  parameter int T_REFRAC    = 4,
  parameter int TRACE_MAX   = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                learn_en,
  input  logic [N_IN-1:0]     x,
  output logic                spike_out,
  output logic [V_W-1:0]      v_out,
  output logic [N_IN*W_W-1:0] w_flat,
  output logic                refrac_active
);

  localparam int TR_W  = trace_width(TRACE_MAX);
  localparam int SUM_W = W_W + $clog2(N_IN);
  localparam int EXT_W = ((SUM_W > V_W) ? SUM_W : V_W) + 2;
  localparam int CNT_W = (T_REFRAC > 0) ? $clog2(T_REFRAC + 1) : 1;
  localparam logic signed [EXT_W-1:0] V_MAX_EXT = {{(EXT_W-V_W){1'b0}}, {V_W{1'b1}}};

  logic [W_W-1:0]          contrib_s [N_IN];
  logic [SUM_W-1:0]        sum_s;
  logic signed [EXT_W-1:0] vn_ext_s;
  logic [V_W-1:0]          vn_s, v_q, v_d;
  logic                    spike_q, spike_d, fire_s;
  lif_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  for (genvar i = 0; i < N_IN; i++) begin : g_syn
    lif_syn_cell #(
      .W_W(W_W), .ETA(ETA), .DECAY_SHIFT(DECAY_SHIFT), .W_MAX(W_MAX),
      .W_INIT(W_INIT), .TRACE_MAX(TRACE_MAX), .TR_W(TR_W)
    ) u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (en),
      .learn_en_i(learn_en),
      .x_i       (x[i]),
      .spike_i   (fire_s),
      .w_o       (w_flat[i*W_W +: W_W]),
      .contrib_o (contrib_s[i])
    );
  end

  // Synaptic adder tree
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      sum_s = sum_s + SUM_W'(contrib_s[i]);
    end
  end

  // Candidate potential, clamped to the representable range, and fire decision
  always_comb begin
    vn_ext_s = $signed(EXT_W'(v_q)) + $signed(EXT_W'(sum_s)) - $signed(EXT_W'(LEAK));
    if (vn_ext_s[EXT_W-1]) begin
      vn_s = '0;
    end else if (vn_ext_s > V_MAX_EXT) begin
      vn_s = '1;
    end else begin
      vn_s = vn_ext_s[V_W-1:0];
    end
    fire_s = en && (state_q == INTEGRATE) && (vn_s >= V_W'(V_THRESH));
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INTEGRATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INTEGRATE: begin
        if (fire_s && (T_REFRAC > 0)) state_d = REFRACTORY;
        else                          state_d = INTEGRATE;
      end
      REFRACTORY: begin
        if (en && (cnt_q == CNT_W'(1))) state_d = INTEGRATE;
        else                            state_d = REFRACTORY;
      end
      default: state_d = INTEGRATE;
    endcase
  end

  // Membrane, spike pulse and refractory counter updates
  always_comb begin
    v_d     = v_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    if (en) begin
      case (state_q)
        INTEGRATE: begin
          if (fire_s) begin
            v_d     = V_W'(V_RESET);
            spike_d = 1'b1;
            cnt_d   = CNT_W'(T_REFRAC);
          end else begin
            v_d = vn_s;
          end
        end
        REFRACTORY: begin
          v_d = V_W'(V_RESET);
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             cnt_d = '0;
        end
        default: begin
          v_d   = V_W'(V_RESET);
          cnt_d = '0;
        end
      endcase
    end else begin
      v_d = v_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q     <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign v_out         = v_q;
  assign spike_out     = spike_q;
  assign refrac_active = (state_q == REFRACTORY);

endmodule

// File: tb/tb_lif_hebbian_nin.sv
// Directed self-checking bench for lif_hebbian_nin with default parameters.
module tb_lif_hebbian_nin;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        learn_en = 1'b0;
  logic [7:0]  x = 8'h00;
  logic        spike_out;
  logic [11:0] v_out;
  logic [63:0] w_flat;
  logic        refrac_active;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] W_ALL32  = {8{8'd32}};
  localparam logic [63:0] W_ALL36  = {8{8'd36}};
  localparam logic [63:0] W_ALL255 = {8{8'd255}};
  localparam logic [63:0] W_LTP1   = {{7{8'd30}}, 8'd36};
  localparam logic [63:0] W_LTP2   = {{7{8'd29}}, 8'd40};

  lif_hebbian_nin dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .learn_en     (learn_en),
    .x            (x),
    .spike_out    (spike_out),
    .v_out        (v_out),
    .w_flat       (w_flat),
    .refrac_active(refrac_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; learn_en = 1'b0; x = 8'h00;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; learn_en = 1'b1; x = 8'hFF;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (v_out !== 12'd0 || spike_out !== 1'b0 || refrac_active !== 1'b0 || w_flat !== W_ALL32) begin
      n_fail++;
      $display("FAIL reset: v=%0d spike=%b refrac=%b w=%h, want v=0 spike=0 refrac=0 w=%h",
               v_out, spike_out, refrac_active, w_flat, W_ALL32);
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_ltp_single();
    do_reset();
    en = 1'b1; learn_en = 1'b1; x = 8'h01;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_tests++;
      if (v_out !== 12'(30 * k) || spike_out !== 1'b0) begin
        n_fail++;
        $display("FAIL ltp_ramp k=%0d: v=%0d spike=%b, want v=%0d spike=0", k, v_out, spike_out, 30 * k);
      end
    end
    tick();
    n_tests++;
    if (spike_out !== 1'b1 || v_out !== 12'd0 || refrac_active !== 1'b1 || w_flat !== W_LTP1) begin
      n_fail++;
      $display("FAIL ltp_spike1: spike=%b v=%0d refrac=%b w=%h, want 1 0 1 %h",
               spike_out, v_out, refrac_active, w_flat, W_LTP1);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (spike_out !== 1'b0 || refrac_active !== 1'b1 || v_out !== 12'd0) begin
        n_fail++;
        $display("FAIL ltp_refrac k=%0d: spike=%b refrac=%b v=%0d, want 0 1 0", k, spike_out, refrac_active, v_out);
      end
    end
    tick();
    n_tests++;
    if (refrac_active !== 1'b0 || v_out !== 12'd0) begin
      n_fail++;
      $display("FAIL ltp_refrac_exit: refrac=%b v=%0d, want 0 0", refrac_active, v_out);
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_tests++;
      if (v_out !== 12'(34 * k) || spike_out !== 1'b0) begin
        n_fail++;
        $display("FAIL ltp_ramp2 k=%0d: v=%0d spike=%b, want v=%0d spike=0", k, v_out, spike_out, 34 * k);
      end
    end
    tick();
    n_tests++;
    if (spike_out !== 1'b1 || w_flat !== W_LTP2) begin
      n_fail++;
      $display("FAIL ltp_spike2: spike=%b w=%h, want spike=1 w=%h", spike_out, w_flat, W_LTP2);
    end
  endtask

  task automatic test_all_inputs();
    do_reset();
    en = 1'b1; learn_en = 1'b1; x = 8'hFF;
    tick();
    n_tests++;
    if (v_out !== 12'd254) begin n_fail++; $display("FAIL all_t1: v=%0d, want 254", v_out); end
    tick();
    n_tests++;
    if (v_out !== 12'd508 || spike_out !== 1'b0) begin
      n_fail++; $display("FAIL all_t2: v=%0d spike=%b, want 508 0", v_out, spike_out);
    end
    tick();
    n_tests++;
    if (spike_out !== 1'b1 || v_out !== 12'd0 || w_flat !== W_ALL36) begin
      n_fail++; $display("FAIL all_t3: spike=%b v=%0d w=%h, want 1 0 %h", spike_out, v_out, w_flat, W_ALL36);
    end
  endtask

  task automatic test_no_learn();
    do_reset();
    en = 1'b1; learn_en = 1'b0; x = 8'h01;
    for (int p = 0; p < 3; p++) begin
      for (int t = 0; t < 22; t++) begin
        tick();
        n_tests++;
        if (spike_out !== (t == 17)) begin
          n_fail++;
          $display("FAIL nolearn_timing p=%0d t=%0d: spike=%b, want %b", p, t, spike_out, (t == 17));
        end
      end
    end
    n_tests++;
    if (w_flat !== W_ALL32) begin n_fail++; $display("FAIL nolearn_w: w=%h, want %h", w_flat, W_ALL32); end
  endtask

  task automatic test_leak_and_stall();
    do_reset();
    en = 1'b1; learn_en = 1'b1; x = 8'h00;
    for (int t = 0; t < 100; t++) begin
      tick();
      n_tests++;
      if (v_out !== 12'd0) begin n_fail++; $display("FAIL leak_floor t=%0d: v=%0d, want 0", t, v_out); end
    end
    x = 8'h01;
    repeat (5) tick();
    en = 1'b0; x = 8'hFF;
    for (int t = 0; t < 10; t++) begin
      tick();
      n_tests++;
      if (v_out !== 12'd150 || spike_out !== 1'b0 || w_flat !== W_ALL32) begin
        n_fail++;
        $display("FAIL stall t=%0d: v=%0d spike=%b w=%h, want 150 0 %h", t, v_out, spike_out, w_flat, W_ALL32);
      end
    end
    en = 1'b1; x = 8'h01;
    tick();
    n_tests++;
    if (v_out !== 12'd180) begin n_fail++; $display("FAIL stall_resume: v=%0d, want 180", v_out); end
    repeat (11) tick();
    n_tests++;
    if (v_out !== 12'd510 || spike_out !== 1'b0) begin
      n_fail++; $display("FAIL stall_prespike: v=%0d spike=%b, want 510 0", v_out, spike_out);
    end
    tick();
    n_tests++;
    if (spike_out !== 1'b1) begin n_fail++; $display("FAIL stall_spike: spike=%b, want 1", spike_out); end
    en = 1'b0;
    tick();
    n_tests++;
    if (spike_out !== 1'b0 || refrac_active !== 1'b1) begin
      n_fail++; $display("FAIL stall_pulse: spike=%b refrac=%b, want 0 1", spike_out, refrac_active);
    end
  endtask

  task automatic test_saturation_and_reset();
    int spikes = 0;
    bit found = 1'b0;
    do_reset();
    en = 1'b1; learn_en = 1'b1; x = 8'hFF;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (spike_out) spikes++;
    end
    n_tests++;
    if (w_flat !== W_ALL255 || spikes < 56) begin
      n_fail++; $display("FAIL sat_w: w=%h spikes=%0d, want %h and >=56 spikes", w_flat, spikes, W_ALL255);
    end
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (spike_out && refrac_active) found = 1'b1;
    end
    n_tests++;
    if (!found || w_flat !== W_ALL255) begin
      n_fail++; $display("FAIL sat_hold: found=%b w=%h, want 1 %h", found, w_flat, W_ALL255);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (refrac_active !== 1'b0 || spike_out !== 1'b0 || v_out !== 12'd0 || w_flat !== W_ALL32) begin
      n_fail++;
      $display("FAIL async_reset: refrac=%b spike=%b v=%0d w=%h, want 0 0 0 %h",
               refrac_active, spike_out, v_out, w_flat, W_ALL32);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ltp_single();
    test_all_inputs();
    test_no_learn();
    test_leak_and_stall();
    test_saturation_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
